// File: rtl/note_sequencer.sv
// Note-table sequencer: steps through a small table of (voice, duration, rest, last)
// entries, pulling one sample per tick from the selected wave-generator voice.
module note_sequencer #(
    parameter int width_p     = 12,
    parameter int voices_p    = 4,
    parameter int clk_div_p   = 567,
    parameter int seq_len_p   = 8,
    parameter int dur_width_p = 16
) (
    input  logic                          clk_i,
    input  logic                          reset_ni,
    input  logic                          start_i,
    input  logic                          stop_i,
    input  logic                          loop_i,
    input  logic                          cfg_we_i,
    input  logic [$clog2(seq_len_p)-1:0]  cfg_addr_i,
    input  logic [$clog2(voices_p)-1:0]   cfg_voice_i,
    input  logic [dur_width_p-1:0]        cfg_dur_i,
    input  logic                          cfg_rest_i,
    input  logic                          cfg_last_i,
    input  logic [voices_p*width_p-1:0]   voice_data_i,
    input  logic [voices_p-1:0]           voice_valid_i,
    output logic [voices_p-1:0]           voice_ready_o,
    output logic [width_p-1:0]            data_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic                          busy_o,
    output logic [$clog2(seq_len_p)-1:0]  step_o,
    output logic                          done_o,
    output logic                          overrun_o
);

    localparam int AW = $clog2(seq_len_p);
    localparam int VW = $clog2(voices_p);
    localparam int TW = $clog2(clk_div_p);
    localparam logic [AW-1:0] LAST_IDX = AW'(seq_len_p - 1);
    localparam logic [TW-1:0] TICK_MAX = TW'(clk_div_p - 1);

    typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;
    state_t state_q, state_d;

    logic [VW-1:0]          tbl_voice [seq_len_p];
    logic [dur_width_p-1:0] tbl_dur   [seq_len_p];
    logic                   tbl_rest  [seq_len_p];
    logic                   tbl_last  [seq_len_p];

    logic [TW-1:0]          tick_cnt_q;
    logic [dur_width_p-1:0] dur_cnt_q;
    logic [AW-1:0]          step_q;
    logic                   done_q;
    logic                   overrun_q;
    logic [width_p-1:0]     data_p1;
    logic                   vld_p1;

    logic [VW-1:0]          cur_voice;
    logic [dur_width_p-1:0] cur_dur, dur_eff, dur_inc;
    logic                   cur_rest, cur_last;
    logic                   tick, step_end, seq_end, start_go;
    logic [width_p-1:0]     sample;

    always_comb begin
        cur_voice = tbl_voice[step_q];
        cur_dur   = tbl_dur[step_q];
        cur_rest  = tbl_rest[step_q];
        cur_last  = tbl_last[step_q];
        tick      = (state_q == PLAY) && (tick_cnt_q == TICK_MAX);
        // A zero duration would never match the incremented counter, so it plays as one tick
        dur_eff   = (cur_dur == '0) ? dur_width_p'(1) : cur_dur;
        dur_inc   = dur_cnt_q + dur_width_p'(1);
        step_end  = tick && (dur_inc == dur_eff);
        seq_end   = step_end && (cur_last || (step_q == LAST_IDX));
        start_go  = start_i && !stop_i && (state_q != PLAY);
        sample    = (cur_rest || !voice_valid_i[cur_voice]) ? '0
                  : voice_data_i[cur_voice*width_p +: width_p];
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) state_q <= IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (stop_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: if (start_i) state_d = PLAY;
                PLAY:       if (seq_end && !loop_i) state_d = DONE;
                default:    state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        voice_ready_o = '0;
        if (tick && !cur_rest) voice_ready_o[cur_voice] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            tick_cnt_q <= '0;
            dur_cnt_q  <= '0;
            step_q     <= '0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            done_q <= (state_q == PLAY) && (state_d == DONE);
            if (start_go) begin
                tick_cnt_q <= '0;
                dur_cnt_q  <= '0;
                step_q     <= '0;
                overrun_q  <= 1'b0;
            end else if (state_q == PLAY) begin
                tick_cnt_q <= (tick_cnt_q == TICK_MAX) ? '0 : tick_cnt_q + TW'(1);
                if (step_end) begin
                    dur_cnt_q <= '0;
                    if (!seq_end)     step_q <= step_q + AW'(1);
                    else if (loop_i)  step_q <= '0;
                end else if (tick) begin
                    dur_cnt_q <= dur_inc;
                end
                if (tick && vld_p1 && !ready_i) overrun_q <= 1'b1;
            end
        end
    end

    // ---- output sample stage ----
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            data_p1 <= '0;
            vld_p1  <= 1'b0;
        end else if (tick) begin
            data_p1 <= sample;
            vld_p1  <= 1'b1;
        end else if (vld_p1 && ready_i) begin
            vld_p1  <= 1'b0;
        end
    end

    // Reset defaults make every entry a one-tick silent terminator
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int i = 0; i < seq_len_p; i++) begin
                tbl_voice[i] <= '0;
                tbl_dur[i]   <= dur_width_p'(1);
                tbl_rest[i]  <= 1'b1;
                tbl_last[i]  <= 1'b1;
            end
        end else if (cfg_we_i && (state_q != PLAY)) begin
            tbl_voice[cfg_addr_i] <= cfg_voice_i;
            tbl_dur[cfg_addr_i]   <= cfg_dur_i;
            tbl_rest[cfg_addr_i]  <= cfg_rest_i;
            tbl_last[cfg_addr_i]  <= cfg_last_i;
        end
    end

    assign data_o    = data_p1;
    assign valid_o   = vld_p1;
    assign busy_o    = (state_q == PLAY);
    assign step_o    = step_q;
    assign done_o    = done_q;
    assign overrun_o = overrun_q;

endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 Parameter width_p, default 12: sample width of every voice and of data_o.
REQ-002 Parameter voices_p, default 4: number of wave-generator voices sequenced.
REQ-003 Parameter clk_div_p, default 567: clocks per sample tick; legal range is 2 or more.
REQ-004 Parameter seq_len_p, default 8: number of note-table entries.
REQ-005 Parameter dur_width_p, default 16: width of the duration field, in samples.
REQ-006 clk_i input 1: single clock; all state changes on the rising edge.
REQ-007 reset_ni input 1: asynchronous active-low reset.
REQ-008 start_i input 1: begin playback at step 0.
REQ-009 stop_i input 1: abort playback and return to IDLE.
REQ-010 loop_i input 1: sampled at end of table; 1 = wrap to step 0, 0 = finish.
REQ-011 cfg_we_i input 1: note-table write strobe.
REQ-012 cfg_addr_i input $clog2(seq_len_p): table entry written.
REQ-013 cfg_voice_i input $clog2(voices_p): voice index for the entry.
REQ-014 cfg_dur_i input dur_width_p: entry duration in sample ticks.
REQ-015 cfg_rest_i input 1: entry is silence.
REQ-016 cfg_last_i input 1: entry is the last of the sequence.
REQ-017 voice_data_i input voices_p*width_p: voice v sample at bits [v*width_p +: width_p].
REQ-018 voice_valid_i input voices_p: per-voice valid.
REQ-019 voice_ready_o output voices_p: per-voice advance strobe, which drives the wave generator ready_i.
REQ-020 data_o output width_p: sequenced sample.
REQ-021 valid_o output 1: data_o holds a new sample.
REQ-022 ready_i input 1: downstream accepts data_o.
REQ-023 busy_o output 1: state is PLAY.
REQ-024 step_o output $clog2(seq_len_p): current table index.
REQ-025 done_o output 1: one-cycle pulse on natural sequence end.
REQ-026 overrun_o output 1: sticky flag, set when a sample is lost downstream.

Function
REQ-027 The FSM SHALL have exactly three states (IDLE, PLAY, DONE), and stop_i SHALL force IDLE from any state with priority over start_i.
REQ-028 start_i in IDLE or DONE SHALL enter PLAY with step = 0, tick counter = 0 and duration counter = 0; start_i in PLAY SHALL be ignored.
REQ-029 In PLAY the tick counter SHALL count 0..clk_div_p-1 and wrap; a tick occurs in the cycle where the count equals clk_div_p-1.
REQ-030 In a tick cycle, voice_ready_o SHALL be one-hot at the current entry's voice, or all zero for a rest entry; otherwise it SHALL be zero.
REQ-031 On a tick, data_o SHALL load the current voice sample, or zero when rest = 1 or that voice_valid_i = 0.
REQ-032 valid_o SHALL rise in the cycle after the tick and hold until a cycle with ready_i = 1.
REQ-033 A tick while valid_o = 1 and ready_i = 0 SHALL set overrun_o and overwrite data_o; overrun_o clears only on reset or start_i.
REQ-034 The duration counter SHALL increment on each tick; when it reaches max(dur, 1), the step SHALL end, with dur = 0 treated as 1.
REQ-035 At step end, if the entry has last = 0 and step < seq_len_p-1, step SHALL advance by 1 and the duration counter SHALL clear.
REQ-036 At step end on a last entry or on index seq_len_p-1: if loop_i = 1, step SHALL go to 0; otherwise the FSM SHALL enter DONE and done_o SHALL pulse for one cycle.
REQ-037 cfg_we_i SHALL write the table in IDLE or DONE and SHALL be ignored in PLAY.
REQ-038 Any pending valid_o SHALL still complete its handshake in IDLE or DONE; no new ticks SHALL occur outside PLAY.

Reset
REQ-039 While reset_ni = 0, all outputs SHALL be 0 and the FSM SHALL be in IDLE.
REQ-040 While reset_ni = 0, every table entry SHALL be voice 0, dur 1, rest 1, last 1.
REQ-041 Reset asserted mid-PLAY SHALL take effect asynchronously, and no voice_ready_o pulse SHALL occur after it.

Verification (clk_div_p = 4, seq_len_p = 4, voices_p = 2, ready_i = 1 unless stated)
REQ-042 Table {v0 d2, v1 d3 last}, voice data 0x100/0x200, start_i -> ticks every 4 clocks; voice_ready_o = 01 twice, then 10 three times; data_o = 0x100 x2, 0x200 x3; done_o pulses once; FSM ends in DONE.
REQ-043 Same table with loop_i = 1 -> step_o sequence 0,0,1,1,1,0,...; done_o is never asserted.
REQ-044 Rest entry d2 followed by v1 d1 last -> voice_ready_o = 00 on the two rest ticks; data_o = 0 on those ticks; then 0x200.
REQ-045 ready_i held at 0 across two ticks -> overrun_o = 1; data_o = the second sample; a subsequent start_i clears overrun_o.
REQ-046 stop_i and start_i asserted together in PLAY -> IDLE, busy_o = 0; a cfg write made in PLAY is ignored, and the same write made in IDLE takes effect.
REQ-047 reset_ni pulled low two clocks before a tick -> all outputs are 0 immediately; no voice_ready_o pulse at the expected tick; table restored to the reset defaults.
